// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing logic:
// forwarding-select codes, the shadow destination entry and its hit test.
package cpu_pipe_pkg;

    localparam int SHADOW_AW = 5;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WR   = 2'b10;
    localparam logic [1:0] FWD_LATE = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic                 reg_wr;
        logic [SHADOW_AW-1:0] rw;
        logic                 load;
    } shadow_t;

    typedef enum logic [1:0] {
        CYC_RUN,
        CYC_STALL,
        CYC_FLUSH
    } cyc_e;

    // $0 is hardwired, so it never matches a producer.
    function automatic logic hit(input shadow_t s, input logic [SHADOW_AW-1:0] r);
        return s.valid & s.reg_wr & (s.rw == r) & (r != '0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard inputs and pipeline control / forwarding outputs of the
// sequencing controller, bundled with pipeline-side and controller-side views.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_reg_wr;
    logic [REG_AW-1:0] id_rw;
    logic              id_load;
    logic              ex_taken;

    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_reg_wr, id_rw, id_load, ex_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_reg_wr, id_rw, id_load, ex_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_select.sv
// Priority compare of one source register against the EX, MEM and WR shadow
// entries; the newest producer wins.
module fwd_select
    import cpu_pipe_pkg::*;
(
    input  logic [SHADOW_AW-1:0] src,
    input  shadow_t              ex_s,
    input  shadow_t              mem_s,
    input  shadow_t              wr_s,
    output logic [1:0]           sel
);

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = FWD_RF;
        if (hit(ex_s, src)) begin
            sel = FWD_MEM;
        end else if (hit(mem_s, src)) begin
            sel = FWD_WR;
        end else if (hit(wr_s, src)) begin
            sel = FWD_LATE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller: tracks destination info for EX/MEM/WR, resolves
// load-use stalls and taken-branch flushes, and registers EX forwarding selects.
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW = SHADOW_AW,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  ctl
);

    shadow_t    ex_s;
    shadow_t    mem_s;
    shadow_t    wr_s;
    shadow_t    id_entry;
    logic       id_valid;
    logic       stall;
    logic       flush;
    logic       advance;
    cyc_e       cyc;
    logic [1:0] sel_rs;
    logic [1:0] sel_rt;

    assign id_entry = '{valid: 1'b1, reg_wr: ctl.id_reg_wr, rw: ctl.id_rw, load: ctl.id_load};

    assign stall = id_valid & ex_s.load &
                   ((hit(ex_s, ctl.id_rs) & ctl.id_use_rs) |
                    (hit(ex_s, ctl.id_rt) & ctl.id_use_rt));
    assign flush = ctl.ex_taken & ex_s.valid;

    // A taken branch squashes the ID instruction, so it overrides any stall.
    always_comb begin
        cyc = CYC_RUN;
        if (flush) begin
            cyc = CYC_FLUSH;
        end else if (stall) begin
            cyc = CYC_STALL;
        end
    end

    assign advance = id_valid & (cyc == CYC_RUN);

    always_comb begin
        ctl.pc_we       = 1'b1;
        ctl.ifid_we     = 1'b1;
        ctl.ifid_flush  = 1'b0;
        ctl.idex_bubble = 1'b0;
        case (cyc)
            CYC_STALL: begin
                ctl.pc_we       = 1'b0;
                ctl.ifid_we     = 1'b0;
                ctl.idex_bubble = 1'b1;
            end
            CYC_FLUSH: begin
                ctl.ifid_flush  = 1'b1;
                ctl.idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    fwd_select u_fwd_rs (
        .src   (ctl.id_rs),
        .ex_s  (ex_s),
        .mem_s (mem_s),
        .wr_s  (wr_s),
        .sel   (sel_rs)
    );

    fwd_select u_fwd_rt (
        .src   (ctl.id_rt),
        .ex_s  (ex_s),
        .mem_s (mem_s),
        .wr_s  (wr_s),
        .sel   (sel_rt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_s          <= '0;
            mem_s         <= '0;
            wr_s          <= '0;
            id_valid      <= 1'b0;
            ctl.fwd_a     <= FWD_RF;
            ctl.fwd_b     <= FWD_RF;
            ctl.stall_cnt <= '0;
            ctl.flush_cnt <= '0;
        end else begin
            // NOTE: non-blocking so mem_s and wr_s shift from the old values.
            wr_s  <= mem_s;
            mem_s <= ex_s;
            ex_s  <= advance ? id_entry : '0;

            // A stalled IF/ID keeps its (valid) instruction; only a flush empties it.
            id_valid <= ~flush;

            ctl.fwd_a <= (advance & ctl.id_use_rs) ? sel_rs : FWD_RF;
            ctl.fwd_b <= (advance & ctl.id_use_rt) ? sel_rt : FWD_RF;

            if (cyc == CYC_STALL && ctl.stall_cnt != '1) begin
                ctl.stall_cnt <= ctl.stall_cnt + 1'b1;
            end
            if (cyc == CYC_FLUSH && ctl.flush_cnt != '1) begin
                ctl.flush_cnt <= ctl.flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: instruction sequences drive the ID
// fields, control outputs are checked in-cycle, forwarding selects via a queue.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    localparam logic [3:0] RUN = 4'b1100;  // {pc_we, ifid_we, ifid_flush, idex_bubble}
    localparam logic [3:0] STL = 4'b0001;
    localparam logic [3:0] FLS = 4'b1111;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // One ID cycle: check the previous instruction's EX selects, drive this one,
    // check the combinational controls, and queue its expected EX selects.
    task automatic step(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rw, input logic urs, input logic urt,
                        input logic rwr, input logic ld, input logic tk,
                        input logic [3:0] ctl_exp, input logic [1:0] ea, input logic [1:0] eb);
        exp_t e;
        logic [3:0] ctl_got;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.fwd_a !== e.a || bus.fwd_b !== e.b) begin
                errors++;
                $display("FAIL %s fwd: got a=%b b=%b, want a=%b b=%b",
                         e.nm, bus.fwd_a, bus.fwd_b, e.a, e.b);
            end
        end
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_rw     = rw;
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_reg_wr = rwr;
        bus.id_load   = ld;
        bus.ex_taken  = tk;
        #1;
        ctl_got = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble};
        checks++;
        if (ctl_got !== ctl_exp) begin
            errors++;
            $display("FAIL %s ctl: got %b, want %b", nm, ctl_got, ctl_exp);
        end
        e.a  = ea;
        e.b  = eb;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic rtype(input string nm, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic tk, input logic [3:0] ctl_exp,
                         input logic [1:0] ea, input logic [1:0] eb);
        step(nm, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, tk, ctl_exp, ea, eb);
    endtask

    task automatic lw(input string nm, input logic [4:0] dst, input logic [4:0] base,
                      input logic [3:0] ctl_exp, input logic [1:0] ea);
        step(nm, base, dst, dst, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ctl_exp, ea, 2'b00);
    endtask

    task automatic nop(input string nm, input logic tk, input logic [3:0] ctl_exp);
        step(nm, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tk, ctl_exp, 2'b00, 2'b00);
    endtask

    // Assert reset for one edge with whatever ID fields are currently driven.
    task automatic do_reset(input string nm);
        logic [3:0] ctl_got;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        #1;
        ctl_got = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble};
        checks++;
        if (ctl_got !== RUN) begin
            errors++;
            $display("FAIL %s ctl: got %b, want %b", nm, ctl_got, RUN);
        end
        checks++;
        if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL %s fwd: got a=%b b=%b, want 00 00", nm, bus.fwd_a, bus.fwd_b);
        end
        checks++;
        if (bus.stall_cnt !== 2'd0 || bus.flush_cnt !== 2'd0) begin
            errors++;
            $display("FAIL %s counters: got stall=%0d flush=%0d, want 0 0",
                     nm, bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic expect_cnt(input string nm, input int st, input int fl);
        checks++;
        if (bus.stall_cnt !== CNT_W'(st) || bus.flush_cnt !== CNT_W'(fl)) begin
            errors++;
            $display("FAIL %s counters: got stall=%0d flush=%0d, want %0d %0d",
                     nm, bus.stall_cnt, bus.flush_cnt, st, fl);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_ex_forward();
        do_reset("fwd_ex_reset");
        rtype("add_3_1_2", 5'd3, 5'd1, 5'd2, 1'b0, RUN, 2'b00, 2'b00);
        rtype("sub_4_3_5", 5'd4, 5'd3, 5'd5, 1'b0, RUN, 2'b01, 2'b00);
        // Rt names the EX producer but is not read, so fwd_b stays 00.
        step("ori_rt_unused", 5'd4, 5'd4, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, RUN, 2'b01, 2'b00);
        nop("nop_drain1", 1'b0, RUN);
    endtask

    task automatic test_load_use();
        do_reset("load_use_reset");
        lw("lw_3", 5'd3, 5'd1, RUN, 2'b00);
        rtype("add_stalled", 5'd4, 5'd3, 5'd3, 1'b0, STL, 2'b00, 2'b00);
        rtype("add_after_stall", 5'd4, 5'd3, 5'd3, 1'b0, RUN, 2'b10, 2'b10);
        expect_cnt("load_use_cnt", 1, 0);
        nop("nop_drain2", 1'b0, RUN);
    endtask

    task automatic test_late_forward();
        do_reset("late_reset");
        rtype("prod_7", 5'd7, 5'd1, 5'd2, 1'b0, RUN, 2'b00, 2'b00);
        rtype("u1", 5'd9, 5'd10, 5'd11, 1'b0, RUN, 2'b00, 2'b00);
        rtype("u2", 5'd12, 5'd13, 5'd14, 1'b0, RUN, 2'b00, 2'b00);
        rtype("cons_7_late", 5'd8, 5'd7, 5'd7, 1'b0, RUN, 2'b11, 2'b11);
        rtype("prod_7b_rt0", 5'd7, 5'd8, 5'd0, 1'b0, RUN, 2'b01, 2'b00);
        rtype("v1", 5'd9, 5'd10, 5'd11, 1'b0, RUN, 2'b00, 2'b00);
        rtype("v2", 5'd12, 5'd13, 5'd14, 1'b0, RUN, 2'b00, 2'b00);
        rtype("v3", 5'd15, 5'd16, 5'd17, 1'b0, RUN, 2'b00, 2'b00);
        rtype("cons_7_rf", 5'd18, 5'd0, 5'd7, 1'b0, RUN, 2'b00, 2'b00);
        nop("nop_drain3", 1'b0, RUN);
    endtask

    task automatic test_zero_reg();
        do_reset("zero_reset");
        lw("lw_0", 5'd0, 5'd1, RUN, 2'b00);
        rtype("add_4_0_0", 5'd4, 5'd0, 5'd0, 1'b0, RUN, 2'b00, 2'b00);
        nop("nop_drain4", 1'b0, RUN);
        expect_cnt("zero_cnt", 0, 0);
    endtask

    task automatic test_flush_priority();
        do_reset("flush_reset");
        lw("lw_3f", 5'd3, 5'd1, RUN, 2'b00);
        rtype("add_flushed", 5'd4, 5'd3, 5'd3, 1'b1, FLS, 2'b00, 2'b00);
        // IF/ID was squashed and EX holds a bubble: no stall, and ex_taken is ignored.
        rtype("add_squashed", 5'd4, 5'd3, 5'd3, 1'b1, RUN, 2'b00, 2'b00);
        expect_cnt("flush_cnt", 0, 1);
        nop("nop_drain5", 1'b0, RUN);
    endtask

    task automatic test_saturation();
        do_reset("sat_reset");
        for (int i = 0; i < 5; i++) begin
            lw("sat_lw", 5'd3, 5'd1, RUN, 2'b00);
            rtype("sat_stall", 5'd4, 5'd3, 5'd3, 1'b0, STL, 2'b00, 2'b00);
            rtype("sat_add", 5'd4, 5'd3, 5'd3, 1'b0, RUN, 2'b10, 2'b10);
            expect_cnt("sat_stall_cnt", (i + 1 > 3) ? 3 : i + 1, 0);
        end
        for (int j = 0; j < 5; j++) begin
            nop("sat_nop_a", 1'b0, RUN);
            expect_cnt("sat_flush_cnt", 3, (j > 3) ? 3 : j);
            nop("sat_nop_b", 1'b0, RUN);
            nop("sat_flush", 1'b1, FLS);
        end
        nop("sat_nop_end", 1'b0, RUN);
        expect_cnt("sat_final", 3, 3);
    endtask

    task automatic test_reset_mid_stall();
        do_reset("mid_reset_pre");
        lw("mid_lw", 5'd3, 5'd1, RUN, 2'b00);
        rtype("mid_stall", 5'd4, 5'd3, 5'd3, 1'b0, STL, 2'b00, 2'b00);
        do_reset("mid_stall_reset");
        // The load was discarded, so the same hazard-looking add runs freely.
        rtype("mid_add_free", 5'd4, 5'd3, 5'd3, 1'b0, RUN, 2'b00, 2'b00);
        nop("nop_drain6", 1'b0, RUN);
        expect_cnt("mid_cnt", 0, 0);
    endtask

    initial begin
        bus.id_rs     = '0;
        bus.id_rt     = '0;
        bus.id_rw     = '0;
        bus.id_use_rs = 1'b0;
        bus.id_use_rt = 1'b0;
        bus.id_reg_wr = 1'b0;
        bus.id_load   = 1'b0;
        bus.ex_taken  = 1'b0;

        test_reset();
        test_ex_forward();
        test_load_use();
        test_late_forward();
        test_zero_reg();
        test_flush_priority();
        test_saturation();
        test_reset_mid_stall();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WR).
- Keeps a shadow pipeline of destination-register information for the EX, MEM and WR stages.
- From that state it drives PC/IF-ID write enables, bubble insertion and flush.
- It also drives registered forwarding selects for the EX-stage ALU operands, and saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- id_rs  in  REG_AW  Rs field of the instruction in ID.
- id_rt  in  REG_AW  Rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads Rs.
- id_use_rt  in  1  ID instruction reads Rt (R-type, sw, beq, bne).
- id_reg_wr  in  1  ID instruction writes a register.
- id_rw  in  REG_AW  destination register of the ID instruction, after RegDst selection.
- id_load  in  1  ID instruction is lw (MemToReg).
- ex_taken  in  1  branch in EX resolved taken.
- pc_we  out  1  PC update enable.
- ifid_we  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register loads all-zero (NOP).
- idex_bubble  out  1  ID/EX control bits load zero.
- fwd_a  out  2  EX operand-A source select.
- fwd_b  out  2  EX operand-B source select.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:
- Shadow entries ex_s, mem_s and wr_s each hold {valid, reg_wr, rw, load}.
  - Each clock: wr_s <= mem_s, mem_s <= ex_s.
  - ex_s <= ID fields when the ID instruction advances, else ex_s <= invalid (bubble).
  - An internal id_valid flag marks whether IF/ID holds a real instruction. It is cleared by reset and by flush, and set when IF/ID loads normally.
- Hit definition: hit(s, r) = s.valid & s.reg_wr & (s.rw == r) & (r != 0). Register $0 never causes a stall or a forward.
- Load-use stall condition, combinational, evaluated in the current cycle: stall = id_valid & ex_s.load & (hit(ex_s, id_rs) & id_use_rs | hit(ex_s, id_rt) & id_use_rt).
- Taken-branch flush condition: flush = ex_taken & ex_s.valid. Flush has priority over stall.
- Output drive, all combinational:
  - Normal cycle: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
  - Stall cycle: pc_we=0, ifid_we=0, idex_bubble=1.
  - Flush cycle: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1.
  - When id_valid=0, the ID fields are ignored and treated as a bubble.
- Stall duration: exactly one cycle per load-use hazard. On the next cycle the load is in MEM, so no second stall occurs.
- Forward select encoding for fwd_a/fwd_b:
  - 00: register file.
  - 01: EX/MEM ALU result.
  - 10: WR-stage busW.
  - 11: late-write latch, i.e. the value written by WR in the previous cycle, because the register file has no write-through.
- Forward select computation:
  - Computed in ID for the instruction that advances into EX, then registered, so fwd_a/fwd_b are stable for the whole EX cycle.
  - Priority, newest producer first: hit(ex_s) -> 01, else hit(mem_s) -> 10, else hit(wr_s) -> 11, else 00.
  - fwd_b applies only when id_use_rt=1. fwd_a applies only when id_use_rs=1.
  - On a bubble, or when the operand is unused, the select registers load 00.
- Counters:
  - stall_cnt increments on each stall cycle; flush_cnt increments on each flush cycle.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (rst=1 at a clock edge):
  - All shadow entries are invalid, id_valid=0, fwd_a/fwd_b=00, both counters=0.
  - Combinational outputs then give pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
  - Reset asserted mid-stall or mid-flush discards all state; there is no residual stall.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WR=2'b10, FWD_LATE=2'b11.
  - The shadow-entry struct type {valid, reg_wr, rw[REG_AW], load}.
- One natural sub-module: fwd_select, the combinational priority compare of one source register against three shadow entries. It is instantiated twice, once for Rs and once for Rt.

Test Plan:
- Reset, then `add $3,$1,$2` followed by `sub $4,$3,$5` -> for sub in EX: fwd_a=01, fwd_b=00, no stall.
- `lw $3,0($1)` followed by `add $4,$3,$3` -> one cycle of pc_we=0, ifid_we=0, idex_bubble=1, with stall_cnt=1. The add then enters EX with fwd_a=fwd_b=10.
- Producer to $7, then two unrelated instructions, then a consumer of $7 -> consumer EX fwd=11. With three intervening instructions -> fwd=00.
- Producer and consumer use $0 (e.g. `lw $0` then `add $4,$0,$0`) -> no stall, fwd=00 on both operands.
- Branch in EX with ex_taken=1 while the ID instruction has a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_we=1, flush_cnt=1, stall_cnt unchanged.
- Preload both counters to max-1 via repeated events (CNT_W=2), then 3 more events -> counters hold 3. Assert rst during a stall -> next cycle all outputs take their reset values.
